// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the sync_fifo_flags family.
package sync_fifo_pkg;

  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic bit af_thresh_ok(input int af, input int asize);
    return (af >= 1) && (af <= fifo_depth(asize));
  endfunction

  function automatic bit ae_thresh_ok(input int ae, input int asize);
    return (ae >= 0) && (ae <= fifo_depth(asize) - 1);
  endfunction

  function automatic bit fwft_ok(input int fwft);
    return (fwft == 0) || (fwft == 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  // NOTE: storage is deliberately not reset; pointers define validity, and a reset
  // here would turn the array into flops instead of RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard/FWFT read mode, fill level, almost flags,
// synchronous flush and sticky overflow/underflow errors.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_flush,
  input  logic             i_clr_err,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_wfull,
  output logic             o_rempty,
  output logic [ASIZE:0]   o_level,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int PW = ptr_width(ASIZE);
  localparam logic [PW-1:0] AF_L = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L = PW'(AE_THRESH);

  if (!fwft_ok(FWFT)) begin : g_bad_fwft
    $error("sync_fifo_flags: FWFT must be 0 or 1 (got %0d)", FWFT);
  end
  if (!af_thresh_ok(AF_THRESH, ASIZE)) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH %0d outside 1..depth", AF_THRESH);
  end
  if (!ae_thresh_ok(AE_THRESH, ASIZE)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH %0d outside 0..depth-1", AE_THRESH);
  end

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [DSIZE-1:0] ram_rdata;

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign full   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                  (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign empty  = (wptr_q == rptr_q);
  assign wr_acc = i_wr && !full  && !i_flush;
  assign rd_acc = i_rd && !empty && !i_flush;

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = i_clr_err ? 1'b0 : ovf_q;
    unf_d   = i_clr_err ? 1'b0 : unf_q;

    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // A fresh error outranks a coincident clear.
      if (i_wr && full)  ovf_d = 1'b1;
      if (i_rd && empty) unf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_acc),
    .i_waddr (wptr_q[ASIZE-1:0]),
    .i_wdata (i_wdata),
    .i_raddr (rptr_q[ASIZE-1:0]),
    .o_rdata (ram_rdata)
  );

  if (FWFT == 1) begin : g_fwft
    assign o_rdata = ram_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= ram_rdata;
      end
    end
    assign o_rdata = rdata_q;
  end

  assign o_level        = level_q;
  assign o_wfull        = full;
  assign o_rempty       = empty;
  assign o_almost_full  = (level_q >= AF_L);
  assign o_almost_empty = (level_q <= AE_L);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a standard-read and an FWFT instance share one stimulus stream
// and are compared against a queue-based reference.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] rdata0, rdata1;
  logic [3:0] level0, level1;
  logic       wfull0, rempty0, af0, ae0, ovf0, unf0;
  logic       wfull1, rempty1, af1, ae1, ovf1, unf1;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic [7:0] last0 = '0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
    .i_flush(flush), .i_clr_err(clr_err), .o_rdata(rdata0), .o_wfull(wfull0),
    .o_rempty(rempty0), .o_level(level0), .o_almost_full(af0), .o_almost_empty(ae0),
    .o_overflow(ovf0), .o_underflow(unf0)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
    .i_flush(flush), .i_clr_err(clr_err), .o_rdata(rdata1), .o_wfull(wfull1),
    .o_rempty(rempty1), .o_level(level1), .o_almost_full(af1), .o_almost_empty(ae1),
    .o_overflow(ovf1), .o_underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".lvl0"},  32'(level0),  32'(n));
    check({tag, ".lvl1"},  32'(level1),  32'(n));
    check({tag, ".full0"}, 32'(wfull0),  32'(n == 8));
    check({tag, ".full1"}, 32'(wfull1),  32'(n == 8));
    check({tag, ".emp0"},  32'(rempty0), 32'(n == 0));
    check({tag, ".emp1"},  32'(rempty1), 32'(n == 0));
    check({tag, ".af0"},   32'(af0),     32'(n >= 6));
    check({tag, ".af1"},   32'(af1),     32'(n >= 6));
    check({tag, ".ae0"},   32'(ae0),     32'(n <= 1));
    check({tag, ".ae1"},   32'(ae1),     32'(n <= 1));
    check({tag, ".ovf0"},  32'(ovf0),    32'(m_ovf));
    check({tag, ".ovf1"},  32'(ovf1),    32'(m_ovf));
    check({tag, ".unf0"},  32'(unf0),    32'(m_unf));
    check({tag, ".unf1"},  32'(unf1),    32'(m_unf));
    check({tag, ".rd0"},   32'(rdata0),  32'(last0));
  endtask

  // One clock of stimulus; the reference queue is updated from pre-edge state.
  task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r,
                     input logic fl = 1'b0, input logic clr = 1'b0);
    bit was_full, was_empty;
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (!was_empty) check({tag, ".head1"}, 32'(rdata1), 32'(q[0]));
    wr = w; wdata = d; rd = r; flush = fl; clr_err = clr;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (r && !was_empty) last0 = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
    end
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    last0 = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles with a write request that must be ignored.
    wr = 1'b1; wdata = 8'h3C;
    do_reset(2);
    wr = 1'b0;
    check_all("reset");
    check("reset.rempty", 32'(rempty0), 32'd1);
    check("reset.ae",     32'(ae0),     32'd1);

    // Fill 0x01..0x08, then a 9th write overflows.
    for (int i = 1; i <= 8; i++) cyc($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0);
    check("fill.level8", 32'(level0), 32'd8);
    cyc("fill9", 1'b1, 8'h99, 1'b0);
    check("fill9.ovf", 32'(ovf1), 32'd1);

    // Drain in order; standard mode shows data the cycle after the pop.
    for (int i = 1; i <= 8; i++) begin
      cyc($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1);
      check($sformatf("drain%0d.data", i), 32'(rdata0), 32'(i));
    end
    cyc("drain9", 1'b0, 8'h00, 1'b1);
    check("drain9.unf",  32'(unf0),   32'd1);
    check("drain9.hold", 32'(rdata0), 32'h08);
    cyc("clr1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Wrap: level 4, then 20 simultaneous read/write cycles across pointer rollover.
    for (int i = 0; i < 4; i++) cyc("pre_wrap", 1'b1, 8'(8'h10 + i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc($sformatf("wrap%0d", k), 1'b1, 8'(8'h20 + k), 1'b1);
      check($sformatf("wrap%0d.lvl", k), 32'(level0), 32'd4);
    end

    // Full with simultaneous write+read: read wins, 0xAA dropped.
    for (int i = 0; i < 4; i++) cyc("refill", 1'b1, 8'(8'h40 + i), 1'b0);
    cyc("full_rw", 1'b1, 8'hAA, 1'b1);
    check("full_rw.lvl", 32'(level0), 32'd7);
    check("full_rw.ovf", 32'(ovf0),   32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("drain_aa%0d", i), 1'b0, 8'h00, 1'b1);
      check($sformatf("drain_aa%0d.not_aa", i), 32'(rdata0 == 8'hAA), 32'd0);
    end
    cyc("clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Empty with simultaneous write+read: write lands, read flagged.
    cyc("empty_rw", 1'b1, 8'h5A, 1'b1);
    check("empty_rw.lvl", 32'(level1), 32'd1);
    check("empty_rw.unf", 32'(unf1),   32'd1);

    // Flush at level 5 with write+read asserted: both ignored, errors kept.
    for (int i = 0; i < 4; i++) cyc("pre_flush", 1'b1, 8'(8'h61 + i), 1'b0);
    check("pre_flush.lvl", 32'(level0), 32'd5);
    cyc("flush", 1'b1, 8'h77, 1'b1, 1'b1);
    check("flush.lvl",    32'(level0),  32'd0);
    check("flush.rempty", 32'(rempty1), 32'd1);
    check("flush.unf",    32'(unf0),    32'd1);

    // Clear coinciding with a new underflow: the error stays set.
    cyc("clr_vs_err", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("clr_vs_err.unf", 32'(unf0), 32'd1);
    cyc("clr3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr3.unf", 32'(unf1), 32'd0);

    // Post-flush data path still works from address 0.
    cyc("post_flush_w", 1'b1, 8'hC3, 1'b0);
    cyc("post_flush_r", 1'b0, 8'h00, 1'b1);
    check("post_flush.data", 32'(rdata0), 32'hC3);

    // Reset mid-operation discards entries.
    for (int i = 0; i < 3; i++) cyc("pre_rst", 1'b1, 8'(8'h81 + i), 1'b0);
    do_reset(1);
    check_all("mid_rst");
    check("mid_rst.lvl", 32'(level1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
